// File: rtl/fetch_align.sv
// fetch_align: queues fetch-word halfwords and emits aligned 16/32-bit instructions with PC.
// Define FETCH_ALIGN_PERF_EN to add saturating perf_short/perf_long pop counters.
module fetch_align #(
   parameter int DEPTH_HW = 8,
   parameter int PC_W     = 8
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_data,
   input  logic [PC_W-1:0] in_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [31:0]     out_instr,
   output logic            out_long,
   output logic [PC_W-1:0] out_pc
`ifdef FETCH_ALIGN_PERF_EN
   ,
   output logic [15:0]     perf_short,
   output logic [15:0]     perf_long
`endif
);
   localparam int AW = $clog2(DEPTH_HW);
   localparam int CW = AW + 1;
   typedef enum logic [1:0] {EMPTY, PARTIAL, AVAIL} state_t;
   state_t state, state_next;
   logic [15:0]     mem_hw [DEPTH_HW];
   logic [PC_W-1:0] mem_pc [DEPTH_HW];
   logic [AW-1:0]   rd_ptr, wr_ptr, rd_ptr_next, wr_ptr_next;
   logic [CW-1:0]   count, count_next, n_push, n_pop, remain;
   logic            push, pop, head_long, next_long;
   logic [15:0]     hw0, hw1, first_hw, next_hw;
   assign hw0       = mem_hw[rd_ptr];
   assign hw1       = mem_hw[rd_ptr + AW'(1)];
   assign head_long = hw0[15:14] == 2'b11;
   assign first_hw  = in_pc[1] ? in_data[15:0] : in_data[31:16];
   assign in_ready  = count <= CW'(DEPTH_HW - 2) && !flush;
   assign push      = in_valid && in_ready;
   assign out_valid = state == AVAIL;
   assign pop       = out_valid && out_ready && !flush;
   assign n_push    = push ? (in_pc[1] ? CW'(1) : CW'(2)) : '0;
   assign n_pop     = pop ? (head_long ? CW'(2) : CW'(1)) : '0;
   assign remain    = count - n_pop;
   // When the queue drains this cycle, the next head is the first halfword being pushed.
   assign next_hw   = remain == '0 ? first_hw : mem_hw[rd_ptr + n_pop[AW-1:0]];
   assign out_long  = out_valid && head_long;
   assign out_instr = !out_valid ? '0 : head_long ? {hw0, hw1} : {16'h0, hw0};
   assign out_pc    = out_valid ? mem_pc[rd_ptr] : '0;
   always_comb begin
      count_next  = count + n_push - n_pop;
      rd_ptr_next = rd_ptr + n_pop[AW-1:0];
      wr_ptr_next = wr_ptr + n_push[AW-1:0];
      next_long   = next_hw[15:14] == 2'b11;
      state_next  = count_next == '0 ? EMPTY : (next_long && count_next == CW'(1)) ? PARTIAL : AVAIL;
      if (flush) begin
         count_next  = '0;
         rd_ptr_next = '0;
         wr_ptr_next = '0;
         state_next  = EMPTY;
      end
   end
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state  <= EMPTY;
         count  <= '0;
         rd_ptr <= '0;
         wr_ptr <= '0;
      end else begin
         state  <= state_next;
         count  <= count_next;
         rd_ptr <= rd_ptr_next;
         wr_ptr <= wr_ptr_next;
      end
   end
   always_ff @(posedge clock) begin
      if (push) begin
         mem_hw[wr_ptr] <= first_hw;
         mem_pc[wr_ptr] <= in_pc;
         if (!in_pc[1]) begin
            mem_hw[wr_ptr + AW'(1)] <= in_data[15:0];
            mem_pc[wr_ptr + AW'(1)] <= in_pc + PC_W'(2);
         end
      end
   end
`ifdef FETCH_ALIGN_PERF_EN
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         perf_short <= '0;
         perf_long  <= '0;
      end else if (pop) begin
         if (head_long && perf_long != 16'hFFFF) perf_long <= perf_long + 16'd1;
         if (!head_long && perf_short != 16'hFFFF) perf_short <= perf_short + 16'd1;
      end
   end
`endif
   assert property (@(posedge clock) disable iff (reset) count <= CW'(DEPTH_HW));
endmodule

// File: tb/tb_fetch_align.sv
// tb_fetch_align: directed vector table, hand-written corner sequences and a queue-model random run.
module tb_fetch_align;
   logic clock = 0, reset = 1, flush = 0, in_valid = 0, out_ready = 0;
   logic in_ready, out_valid, out_long;
   logic [31:0] in_data = 0, out_instr;
   logic [7:0] in_pc = 0, out_pc;
   int n_chk = 0, n_fail = 0;
   logic [23:0] mq[$];
   typedef struct {
      logic iv; logic [31:0] d; logic [7:0] pc; logic ordy; logic fl;
      logic ev; logic [31:0] ei; logic el; logic [7:0] ep; logic er;
   } vec_t;
   vec_t vt[$];

   fetch_align dut (
      .clock(clock), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_pc(in_pc),
      .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
      .out_long(out_long), .out_pc(out_pc)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic iv, input logic [31:0] d, input logic [7:0] pc,
                        input logic ordy, input logic fl);
      in_valid = iv; in_data = d; in_pc = pc; out_ready = ordy; flush = fl;
      #1;
   endtask

   task automatic check_out(input string tag, input logic ev, input logic [31:0] ei,
                            input logic el, input logic [7:0] ep, input logic er);
      chk({tag, ".out_valid"}, 32'(out_valid), 32'(ev));
      chk({tag, ".out_instr"}, out_instr, ei);
      chk({tag, ".out_long"}, 32'(out_long), 32'(el));
      chk({tag, ".out_pc"}, 32'(out_pc), 32'(ep));
      chk({tag, ".in_ready"}, 32'(in_ready), 32'(er));
   endtask

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic add(input logic iv, input logic [31:0] d, input logic [7:0] pc, input logic ordy,
                      input logic fl, input logic ev, input logic [31:0] ei, input logic el,
                      input logic [7:0] ep, input logic er);
      vt.push_back('{iv, d, pc, ordy, fl, ev, ei, el, ep, er});
   endtask

   initial begin
      logic iv, ordy, fl, ev, lng, er;
      logic [31:0] d, ei;
      logic [7:0] pc, ep;
      int sz;
      // short pair
      add(1, 32'h1234_5678, 8'h00, 1, 0,  0, 32'h0,         0, 8'h00, 1);
      add(0, 32'h0,         8'h00, 1, 0,  1, 32'h0000_1234, 0, 8'h00, 1);
      add(0, 32'h0,         8'h00, 1, 0,  1, 32'h0000_5678, 0, 8'h02, 1);
      // straddling long instruction
      add(1, 32'h0001_C0DE, 8'h00, 1, 0,  0, 32'h0,         0, 8'h00, 1);
      add(0, 32'h0,         8'h00, 1, 0,  1, 32'h0000_0001, 0, 8'h00, 1);
      add(0, 32'h0,         8'h00, 1, 0,  0, 32'h0,         0, 8'h00, 1);
      add(1, 32'hBEEF_0002, 8'h04, 1, 0,  0, 32'h0,         0, 8'h00, 1);
      add(0, 32'h0,         8'h00, 1, 0,  1, 32'hC0DE_BEEF, 1, 8'h02, 1);
      add(0, 32'h0,         8'h00, 1, 0,  1, 32'h0000_0002, 0, 8'h06, 1);
      // flush then odd branch target
      add(1, 32'h9999_9999, 8'h40, 1, 1,  0, 32'h0,         0, 8'h00, 0);
      add(1, 32'hFFFF_4444, 8'h12, 1, 0,  0, 32'h0,         0, 8'h00, 1);
      add(0, 32'h0,         8'h00, 1, 0,  1, 32'h0000_4444, 0, 8'h12, 1);
      add(0, 32'h0,         8'h00, 1, 0,  0, 32'h0,         0, 8'h00, 1);
      // pc wrap, then flush colliding with both handshakes
      add(1, 32'h1111_2222, 8'hFC, 0, 0,  0, 32'h0,         0, 8'h00, 1);
      add(1, 32'h3333_4444, 8'h00, 0, 0,  1, 32'h0000_1111, 0, 8'hFC, 1);
      add(0, 32'h0,         8'h00, 1, 0,  1, 32'h0000_1111, 0, 8'hFC, 1);
      add(0, 32'h0,         8'h00, 1, 0,  1, 32'h0000_2222, 0, 8'hFE, 1);
      add(0, 32'h0,         8'h00, 1, 0,  1, 32'h0000_3333, 0, 8'h00, 1);
      add(1, 32'h5555_6666, 8'h10, 1, 1,  1, 32'h0000_4444, 0, 8'h02, 0);
      add(0, 32'h0,         8'h00, 1, 0,  0, 32'h0,         0, 8'h00, 1);
      add(0, 32'h0,         8'h00, 1, 0,  0, 32'h0,         0, 8'h00, 1);

      drive(0, 0, 0, 0, 0);
      check_out("reset", 0, 0, 0, 0, 1);
      repeat (2) @(posedge clock);
      #1 reset = 0;

      foreach (vt[i]) begin
         drive(vt[i].iv, vt[i].d, vt[i].pc, vt[i].ordy, vt[i].fl);
         check_out($sformatf("vec%0d", i), vt[i].ev, vt[i].ei, vt[i].el, vt[i].ep, vt[i].er);
         tick;
      end

      // fill to DEPTH_HW with short instructions under backpressure
      for (int k = 0; k < 4; k++) begin
         drive(1, {16'h0100 + 16'(k), 16'h0200 + 16'(k)}, 8'h30 + 8'(4 * k), 0, 0);
         chk($sformatf("fill%0d.in_ready", k), 32'(in_ready), 1);
         tick;
      end
      drive(1, 32'h7777_7777, 8'h40, 0, 0);
      check_out("full", 1, 32'h0000_0100, 0, 8'h30, 0);
      tick;
      drive(0, 0, 0, 1, 0);
      check_out("pop8", 1, 32'h0000_0100, 0, 8'h30, 0);
      tick;
      drive(0, 0, 0, 0, 0);
      check_out("hold7", 1, 32'h0000_0200, 0, 8'h32, 0);
      tick;
      drive(0, 0, 0, 1, 0);
      check_out("pop7", 1, 32'h0000_0200, 0, 8'h32, 0);
      tick;
      drive(0, 0, 0, 0, 0);
      check_out("at6", 1, 32'h0000_0101, 0, 8'h34, 1);
      tick;
      drive(0, 0, 0, 0, 1);
      tick;

      // asynchronous reset with count=5
      drive(1, 32'h1000_1001, 8'h20, 0, 0); tick;
      drive(1, 32'h1002_1003, 8'h24, 0, 0); tick;
      drive(1, 32'h1004_1005, 8'h2A, 0, 0); tick;
      drive(0, 0, 0, 0, 0);
      check_out("cnt5", 1, 32'h0000_1000, 0, 8'h20, 1);
      #2 reset = 1;
      #1 check_out("async_rst", 0, 0, 0, 0, 1);
      tick;
      reset = 0;
      drive(0, 0, 0, 1, 0);
      check_out("post_rst", 0, 0, 0, 0, 1);
      tick;

      // random traffic against a halfword-queue model
      mq.delete();
      for (int c = 0; c < 3000; c++) begin
         iv = $urandom_range(0, 99) < 70;
         d = $urandom;
         pc = 8'($urandom) & 8'hFE;
         ordy = $urandom_range(0, 99) < 60;
         fl = $urandom_range(0, 99) < 4;
         drive(iv, d, pc, ordy, fl);
         sz = mq.size();
         lng = sz > 0 && mq[0][23:22] == 2'b11;
         ev = sz >= 1 && (!lng || sz >= 2);
         ei = 0;
         ep = 0;
         if (ev) begin
            ep = mq[0][7:0];
            if (lng) ei = {mq[0][23:8], mq[1][23:8]};
            else ei = {16'h0, mq[0][23:8]};
         end
         er = (8 - sz >= 2) && !fl;
         check_out($sformatf("rnd%0d", c), ev, ei, ev && lng, ep, er);
         if (fl) mq.delete();
         else begin
            if (ev && ordy) repeat (lng ? 2 : 1) void'(mq.pop_front());
            if (iv && er) begin
               if (!pc[1]) begin
                  mq.push_back({d[31:16], pc});
                  mq.push_back({d[15:0], pc + 8'd2});
               end else mq.push_back({d[15:0], pc});
            end
         end
         tick;
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
